// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, one 4-bit digit per cycle; BCD correction only when SERIAL_ADDER_DECIMAL_EN is defined
module serial_adder #(
  parameter int NrOfBits = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Subtract,
  input  logic                Decimal,
  input  logic                CarryIn,
  input  logic [NrOfBits-1:0] DataA,
  input  logic [NrOfBits-1:0] DataB,
  output logic                Busy,
  output logic                Done,
  output logic [NrOfBits-1:0] Result,
  output logic                CarryOut,
  output logic                Overflow,
  output logic                Zero,
  output logic                Negative
);
  localparam int Digits = NrOfBits / 4;
  localparam int CntW = $clog2(Digits) + 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q;
  logic [NrOfBits-1:0] a_q, b_q, acc_q, res_q, res_d;
  logic [CntW-1:0] cnt_q;
  logic sub_q, c_q, busy_q, done_q, co_q, ov_q, z_q, n_q;
  logic [3:0] bp, dig;
  logic [4:0] s;
  logic co;
`ifdef SERIAL_ADDER_DECIMAL_EN
  logic dec_q;
`else
  logic unused_decimal;
  assign unused_decimal = Decimal;
`endif
  // adder for the current least-significant digit of the shifting operands
  always_comb begin
    bp = sub_q ? ~b_q[3:0] : b_q[3:0];
    s = {1'b0, a_q[3:0]} + {1'b0, bp} + {4'b0, c_q};
`ifdef SERIAL_ADDER_DECIMAL_EN
    dig = !dec_q ? s[3:0] : sub_q ? (s[4] ? s[3:0] : s[3:0] + 4'd10) : (s > 5'd9 ? s[3:0] + 4'd6 : s[3:0]);
    co = (dec_q && !sub_q) ? (s > 5'd9) : s[4];
`else
    dig = s[3:0];
    co = s[4];
`endif
    res_d = NrOfBits'({dig, acc_q} >> 4);
  end
  // control FSM, operand shifters and registered result/status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
`ifdef SERIAL_ADDER_DECIMAL_EN
      dec_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ADD: begin
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          c_q <= co;
          acc_q <= res_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res_q <= res_d;
            co_q <= co;
            ov_q <= (a_q[3] == bp[3]) && (s[3] != a_q[3]);
            z_q <= res_d == '0;
            n_q <= res_d[NrOfBits-1];
          end
        end
        default: begin
          if (Start) begin
            state_q <= ADD;
            busy_q <= 1'b1;
            a_q <= DataA;
            b_q <= DataB;
            sub_q <= Subtract;
            c_q <= CarryIn;
            cnt_q <= CntW'(Digits - 1);
`ifdef SERIAL_ADDER_DECIMAL_EN
            dec_q <= Decimal;
`endif
          end else begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end
  assign Busy = busy_q;
  assign Done = done_q;
  assign Result = res_q;
  assign CarryOut = co_q;
  assign Overflow = ov_q;
  assign Zero = z_q;
  assign Negative = n_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against a word-level reference model
module tb_serial_adder;
  localparam int W = 8;
  localparam int D = W / 4;
  logic Clock = 1'b0;
  logic Reset, Start, Subtract, Decimal, CarryIn;
  logic [W-1:0] DataA, DataB, Result;
  logic Busy, Done, CarryOut, Overflow, Zero, Negative;
  int n_chk = 0;
  int n_fail = 0;
  serial_adder #(.NrOfBits(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Subtract(Subtract), .Decimal(Decimal),
    .CarryIn(CarryIn), .DataA(DataA), .DataB(DataB), .Busy(Busy), .Done(Done), .Result(Result),
    .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic dec,
                                input logic cin, output logic [W-1:0] r, output logic c, output logic v,
                                output logic z, output logic n);
    logic [W-1:0] bb;
    logic [W:0] full;
    int cc, s;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    r = full[W-1:0];
    c = full[W];
    v = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`ifdef SERIAL_ADDER_DECIMAL_EN
    if (dec) begin
      cc = cin ? 1 : 0;
      for (int i = 0; i < D; i++) begin
        s = int'(a[4*i+:4]) + int'(bb[4*i+:4]) + cc;
        if (i == D - 1) v = (a[W-1] == bb[W-1]) && (s[3] != a[W-1]);
        if (sub) begin
          cc = (s >= 16) ? 1 : 0;
          s = (cc == 1) ? s - 16 : (s + 10) % 16;
        end else begin
          cc = (s > 9) ? 1 : 0;
          s = (cc == 1) ? (s + 6) % 16 : s;
        end
        r[4*i+:4] = s[3:0];
      end
      c = cc[0];
    end
`else
    if (dec) c = c;
`endif
    z = (r == '0);
    n = r[W-1];
  endfunction
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic dec, input logic cin);
    logic [W-1:0] er, prev;
    logic ec, ev, ez, en;
    int lat;
    model(a, b, sub, dec, cin, er, ec, ev, ez, en);
    prev = Result;
    DataA = a;
    DataB = b;
    Subtract = sub;
    Decimal = dec;
    CarryIn = cin;
    Start = 1'b1;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
      if (!Done) begin
        chk("hold_result", Result, prev);
        chk("busy_in_add", Busy, 1);
      end
      Start = Done ? 1'b0 : 1'($urandom);
      DataA = W'($urandom);
      DataB = W'($urandom);
      Subtract = 1'($urandom);
      Decimal = 1'($urandom);
      CarryIn = 1'($urandom);
    end while (!Done && lat < 8);
    chk("done_latency", lat, D + 1);
    chk("busy_at_done", Busy, 0);
    chk("result", Result, er);
    chk("carry", CarryOut, ec);
    chk("overflow", Overflow, ev);
    chk("zero", Zero, ez);
    chk("negative", Negative, en);
  endtask
  task automatic back_to_back();
    logic [W-1:0] qa [13];
    logic [W-1:0] qb [13];
    logic qs [13];
    logic qd [13];
    logic qc [13];
    logic [W-1:0] er;
    logic ec, ev, ez, en;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        @(negedge Clock);
        chk("b2b_done", Done, (i % 3 == 0) ? 1 : 0);
        if (i % 3 == 0) begin
          model(qa[i-3], qb[i-3], qs[i-3], qd[i-3], qc[i-3], er, ec, ev, ez, en);
          chk("b2b_result", Result, er);
          chk("b2b_carry", CarryOut, ec);
          chk("b2b_overflow", Overflow, ev);
        end else chk("b2b_busy", Busy, 1);
      end
      qa[i] = W'($urandom);
      qb[i] = W'($urandom);
      qs[i] = 1'($urandom);
      qd[i] = 1'($urandom);
      qc[i] = 1'($urandom);
      DataA = qa[i];
      DataB = qb[i];
      Subtract = qs[i];
      Decimal = qd[i];
      CarryIn = qc[i];
      Start = (i < 12);
    end
    @(negedge Clock);
    chk("b2b_idle_done", Done, 0);
    chk("b2b_idle_busy", Busy, 0);
  endtask
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Subtract = 1'b0;
    Decimal = 1'b0;
    CarryIn = 1'b0;
    DataA = '0;
    DataB = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_flags", {CarryOut, Overflow, Zero, Negative}, 0);
    Reset = 1'b0;
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("d7f_result", Result, 8'h80);
    chk("d7f_cvzn", {CarryOut, Overflow, Zero, Negative}, 4'b0101);
    do_op(8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
    chk("dsub1_result", Result, 8'hFF);
    chk("dsub1_cvn", {CarryOut, Overflow, Negative}, 3'b001);
    do_op(8'h50, 8'h50, 1'b1, 1'b0, 1'b1);
    chk("dsub2_result", Result, 8'h00);
    chk("dsub2_cz", {CarryOut, Zero}, 2'b11);
`ifdef SERIAL_ADDER_DECIMAL_EN
    do_op(8'h58, 8'h46, 1'b0, 1'b1, 1'b1);
    chk("bcd_add_result", Result, 8'h05);
    chk("bcd_add_carry", CarryOut, 1);
    do_op(8'h46, 8'h12, 1'b1, 1'b1, 1'b1);
    chk("bcd_sub_result", Result, 8'h34);
    chk("bcd_sub_carry", CarryOut, 1);
`else
    do_op(8'h09, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("nodec_result", Result, 8'h0A);
    chk("nodec_carry", CarryOut, 0);
`endif
    repeat (40) do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    DataA = 8'h99;
    DataB = 8'h11;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_result", Result, 0);
    chk("abort_flags", {CarryOut, Overflow, Zero, Negative}, 0);
    repeat (4) begin
      @(negedge Clock);
      chk("abort_no_done", Done, 0);
    end
    do_op(8'h21, 8'h43, 1'b0, 1'b0, 1'b0);
    back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
